alu_stream_engine: RTL

- Parametrised, byte-stream ALU that replaces the single-byte combinational opcode decoder.
- Sits between the UART receiver and transmitter. Consumes framed packets: opcode, reserved byte, 16-bit length, then payload.
- Supports echo, running add, running multiply, and iterative divide over WIDTH-bit little-endian operands.
- Streams results back as bytes with valid/ready handshakes on both sides.

---
 rtl/alu_stream_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_stream_engine.sv
// Byte-stream ALU: parses framed packets (opcode, reserved, 16-bit length, payload)
// and either echoes the payload, drops it, or folds WIDTH-bit little-endian operands
// with add / multiply / restoring divide, then streams the accumulator back LSB first.
module alu_stream_engine #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       div0_o
);
    localparam int unsigned NBYTES = WIDTH / 8;

    typedef enum logic [2:0] {
        StOpcode, StRsvd, StLenLo, StLenHi, StPayload, StDivBusy, StResult
    } state_e;

    typedef enum logic [2:0] {OpEcho, OpAdd, OpMul, OpDiv, OpDrop} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      remain_q, remain_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [3:0]       res_cnt_q, res_cnt_d;
    logic [6:0]       div_cnt_q, div_cnt_d;
    logic             have_acc_q, have_acc_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             div0_q, div0_d;

    logic             rx_fire, tx_fire, tx_free, is_arith;
    logic [15:0]      len_full, payload_len;
    logic [WIDTH-1:0] op_shift;
    logic [WIDTH:0]   rem_shift, rem_trial;
    logic [7:0]       res_byte;

    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_q && tx_ready_i;
    assign tx_free    = !tx_valid_q || tx_ready_i;
    assign is_arith   = (op_q == OpAdd) || (op_q == OpMul) || (op_q == OpDiv);
    assign len_full   = {rx_data_i, len_lo_q};
    assign payload_len = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
    assign res_byte   = 8'(acc_q >> {res_cnt_q, 3'b000});
    // Restoring divide step: acc_q doubles as dividend shift-out and quotient shift-in.
    assign rem_shift  = {rem_q, acc_q[WIDTH-1]};
    assign rem_trial  = rem_shift - {1'b0, divisor_q};

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != StOpcode);
    assign div0_o     = div0_q;

    // Little-endian operand assembly: each new byte enters at the top and shifts down.
    always_comb begin
        op_shift = opnd_q >> 8;
        op_shift[WIDTH-1 -: 8] = rx_data_i;
    end

    // Input acceptance: echo is throttled by the one-entry output register.
    always_comb begin
        case (state_q)
            StPayload:           rx_ready_o = (op_q == OpEcho) ? tx_free : 1'b1;
            StDivBusy, StResult: rx_ready_o = 1'b0;
            default:             rx_ready_o = 1'b1;
        endcase
    end

    // Packet parsing, arithmetic, divider sequencing and result streaming.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        byte_cnt_d = byte_cnt_q;
        res_cnt_d  = res_cnt_q;
        div_cnt_d  = div_cnt_q;
        have_acc_d = have_acc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_fire ? 1'b0 : tx_valid_q;
        div0_d     = 1'b0;

        case (state_q)
            StOpcode: if (rx_fire) begin
                case (rx_data_i)
                    8'hEC:   op_d = OpEcho;
                    8'hAD:   op_d = OpAdd;
                    8'hAC:   op_d = OpMul;
                    8'hD1:   op_d = OpDiv;
                    default: op_d = OpDrop;
                endcase
                state_d = StRsvd;
            end
            StRsvd: if (rx_fire) state_d = StLenLo;
            StLenLo: if (rx_fire) begin
                len_lo_d = rx_data_i;
                state_d  = StLenHi;
            end
            StLenHi: if (rx_fire) begin
                remain_d   = payload_len;
                byte_cnt_d = '0;
                res_cnt_d  = '0;
                have_acc_d = 1'b0;
                // Preload the zero-operand result; the first operand overwrites it.
                acc_d      = (op_q == OpMul) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
                if (payload_len != 16'd0) state_d = StPayload;
                else if (is_arith)        state_d = StResult;
                else                      state_d = StOpcode;
            end
            StPayload: if (rx_fire) begin
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) state_d = is_arith ? StResult : StOpcode;
                if (op_q == OpEcho) begin
                    tx_data_d  = rx_data_i;
                    tx_valid_d = 1'b1;
                end else if (is_arith) begin
                    opnd_d = op_shift;
                    if (byte_cnt_q == 4'(NBYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (!have_acc_q) begin
                            acc_d      = op_shift;
                            have_acc_d = 1'b1;
                        end else begin
                            case (op_q)
                                OpAdd: acc_d = acc_q + op_shift;
                                OpMul: acc_d = acc_q * op_shift;
                                default: begin
                                    if (op_shift == '0) begin
                                        acc_d  = '1;
                                        div0_d = 1'b1;
                                    end else begin
                                        rem_d     = '0;
                                        divisor_d = op_shift;
                                        div_cnt_d = 7'(WIDTH - 1);
                                        state_d   = StDivBusy;
                                    end
                                end
                            endcase
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            StDivBusy: begin
                if (!rem_trial[WIDTH]) begin
                    rem_d = rem_trial[WIDTH-1:0];
                    acc_d = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    acc_d = {acc_q[WIDTH-2:0], 1'b0};
                end
                div_cnt_d = div_cnt_q - 7'd1;
                if (div_cnt_q == '0) state_d = (remain_q == '0) ? StResult : StPayload;
            end
            StResult: if (tx_free) begin
                if (res_cnt_q != 4'(NBYTES)) begin
                    tx_data_d  = res_byte;
                    tx_valid_d = 1'b1;
                    res_cnt_d  = res_cnt_q + 4'd1;
                end else begin
                    // Last result byte is being accepted this cycle.
                    tx_valid_d = 1'b0;
                    state_d    = StOpcode;
                end
            end
            default: state_d = StOpcode;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StOpcode;
            op_q       <= OpDrop;
            len_lo_q   <= '0;
            remain_q   <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            byte_cnt_q <= '0;
            res_cnt_q  <= '0;
            div_cnt_q  <= '0;
            have_acc_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_lo_q   <= len_lo_d;
            remain_q   <= remain_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            byte_cnt_q <= byte_cnt_d;
            res_cnt_q  <= res_cnt_d;
            div_cnt_q  <= div_cnt_d;
            have_acc_q <= have_acc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            div0_q     <= div0_d;
        end
    end

endmodule
